// File: rtl/posit_encode.sv
// Packs sign/scale/normalized mantissa into an N-bit posit (es=ES); define POSIT_NAR_EN to add nar_in.
// Latency r+2 cycles (2 for zero/saturation/NaR); start ignored while busy, no queuing.
module posit_encode #(
  parameter int N  = 32,
  parameter int ES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sign_in,
  input  logic [9:0]   scale_in,
  input  logic [63:0]  mant_in,
`ifdef POSIT_NAR_EN
  input  logic         nar_in,
`endif
  output logic [N-1:0] posit_out,
  output logic         done,
  output logic         busy
);

  localparam int FW = 62;
  localparam int WW = 2 * N;
  localparam int TW = WW + ES + FW;
  localparam int CW = $clog2(N) + 1;
  localparam int SW = $clog2(WW) + 1;
  localparam logic signed [9:0] K_MAX = 10'(N - 2);
  localparam logic signed [9:0] K_MIN = 10'(1 - N);

  typedef enum logic [1:0] {IDLE, REGIME, ROUND, DONE} state_t;

  state_t          state_q, state_n;
  logic            sign_q, neg_q, zero_q, sat_hi_q, sat_lo_q, nar_q;
  logic [ES-1:0]   e_q;
  logic [FW-1:0]   frac_q;
  logic [CW-1:0]   r_q, cnt_q;
  logic [WW-1:0]   work_q;

  logic signed [9:0] k_in;
  logic              sat_hi_in, sat_lo_in, zero_in, nar_w, special_in;
  logic [CW-1:0]     r_in;
  logic              reg_bit;

`ifdef POSIT_NAR_EN
  assign nar_w = nar_in;
`else
  assign nar_w = 1'b0;
`endif

  assign k_in       = $signed(scale_in) >>> ES;
  assign sat_hi_in  = (k_in >= K_MAX);
  assign sat_lo_in  = (k_in <= K_MIN);
  assign zero_in    = (mant_in == '0);
  assign special_in = nar_w | zero_in | sat_hi_in | sat_lo_in;
  // Only meaningful when not saturated, where k fits in CW signed bits
  assign r_in = k_in[9] ? (CW'(1) - k_in[CW-1:0]) : (k_in[CW-1:0] + CW'(2));
  assign reg_bit = neg_q ? (cnt_q == CW'(1)) : (cnt_q != CW'(1));

  // Regime bits sit right-aligned in work_q; left-justify the whole string before field selection
  logic [SW-1:0]  shamt;
  logic [TW-1:0]  full;
  logic [N-2:0]   body, body_rnd;
  logic           guard, sticky, round_up;
  logic [N-1:0]   mag, result;

  assign shamt    = SW'(WW) - SW'(r_q);
  assign full     = {work_q, e_q, frac_q} << shamt;
  assign body     = full[TW-1 -: N-1];
  assign guard    = full[TW-N];
  assign sticky   = |full[TW-N-1:0];
  assign round_up = guard & (sticky | body[0]) & ~(&body);
  assign body_rnd = body + {{(N-2){1'b0}}, round_up};

  always_comb begin
    mag = {1'b0, body_rnd};
    if (body_rnd == '0) mag = {{(N-1){1'b0}}, 1'b1};
    if (sat_hi_q)       mag = {1'b0, {(N-1){1'b1}}};
    if (sat_lo_q)       mag = {{(N-1){1'b0}}, 1'b1};
    if (zero_q)         mag = '0;
    result = sign_q ? (~mag + 1'b1) : mag;
    if (nar_q)          result = {1'b1, {(N-1){1'b0}}};
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start) state_n = special_in ? ROUND : REGIME;
      REGIME:  if (cnt_q == CW'(1)) state_n = ROUND;
      ROUND:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      sat_hi_q  <= 1'b0;
      sat_lo_q  <= 1'b0;
      nar_q     <= 1'b0;
      e_q       <= '0;
      frac_q    <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      work_q    <= '0;
      posit_out <= '0;
    end else begin
      state_q <= state_n;
      case (state_q)
        IDLE: if (start) begin
          sign_q   <= sign_in;
          neg_q    <= k_in[9];
          zero_q   <= zero_in;
          sat_hi_q <= sat_hi_in;
          sat_lo_q <= sat_lo_in;
          nar_q    <= nar_w;
          e_q      <= scale_in[ES-1:0];
          frac_q   <= mant_in[FW-1:0];
          r_q      <= r_in;
          cnt_q    <= r_in;
          work_q   <= '0;
        end
        REGIME: begin
          work_q <= {work_q[WW-2:0], reg_bit};
          cnt_q  <= cnt_q - CW'(1);
        end
        ROUND:   posit_out <= result;
        default: ;
      endcase
    end
  end

  assign done = (state_q == DONE);
  assign busy = (state_q != IDLE);

endmodule
